// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and helpers for the data-memory responder.
//   dmem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES   : bytes per RAM word, one write strobe per byte
//   addr_ok()    : alignment and range check for a byte address
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int WORD_BYTES = 4;

  // True when the byte address is word aligned and its word index
  // falls inside a RAM of 'depth' words.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    logic        aligned;
    logic        inRange;
    logic [31:0] wordIdx;
    wordIdx = {2'b00, addr[31:2]};
    aligned = (addr[1:0] == 2'b00);
    inRange = (wordIdx < depth);
    return aligned && inRange;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if
// Load/store port between the CPU datapath (master) and the data-memory
// responder (slave).
//   req   : request valid, held with the other request fields until ready
//   we    : 1 = write, 0 = read
//   addr  : byte address
//   be    : byte enables for writes, be[i] covers wdata[8i+7:8i]
//   wdata : write data
//   ready : one-cycle completion pulse
//   rdata : read data, meaningful while ready=1 on a good read
//   err   : misaligned or out-of-range access, meaningful while ready=1
interface dmem_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req,
    output we,
    output addr,
    output be,
    output wdata,
    input  ready,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  be,
    input  wdata,
    output ready,
    output rdata,
    output err
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array
// Single-port data RAM with byte-masked synchronous write and a registered
// read. Contents are not reset.
//   i_clk   : rising-edge clock
//   i_en    : access enable for this edge
//   i_we    : 1 = masked write, 0 = read into o_rdata
//   i_be    : byte enables for writes
//   i_idx   : word index
//   i_wdata : write data
//   o_rdata : read data, updated only by an enabled read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           i_clk,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // One access per enabled edge: a write touches only the strobed bytes,
  // a read captures the whole word. o_rdata keeps its value across writes
  // and idle cycles so the owner can hold a completed read.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (i_be[b]) begin
            r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Slave end of the CPU load/store port. Accepts one request at a time,
// waits WAIT_CYCLES cycles, then performs a word read or a byte-masked
// write on the internal RAM and pulses ready for one cycle. Misaligned or
// out-of-range accesses complete with err=1, no RAM write and rdata=0.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   io_bus  : dmem_if slave port (req/we/addr/be/wdata in, ready/rdata/err out)
// Parameters:
//   DEPTH_WORDS : RAM depth in 32-bit words, power of two, >= 2
//   WAIT_CYCLES : wait states between accept and response, 0..15
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  dmem_if.slave io_bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t r_state;
  dmem_state_t w_nextState;

  logic [3:0]  r_count;

  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        r_err;
  logic        r_rdSel;

  logic        w_accept;
  logic        w_ready;
  logic        w_enterResp;

  logic        w_curWe;
  logic [3:0]  w_curBe;
  logic [31:0] w_curAddr;
  logic [31:0] w_curWdata;

  logic        w_ok;
  logic        w_ramEn;
  logic [31:0] w_ramRdata;

  // State register. Reset aborts whatever is in flight by forcing IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and ready decode. req is only looked at in IDLE, so a
  // request left high through RESP is not taken until the following cycle.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.req) begin
          w_accept    = 1'b1;
          w_nextState = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (r_count == 4'd1) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_ready     = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Wait-state counter: loaded on accept, counts down through WAIT and
  // reaches zero on the edge into RESP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 4'd0;
    end else if (w_accept) begin
      r_count <= 4'(WAIT_CYCLES);
    end else if (r_state == WAIT) begin
      r_count <= r_count - 4'd1;
    end
  end

  // Request latch: captured once at accept so later bus changes during the
  // wait states cannot affect the transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= io_bus.we;
      r_be    <= io_bus.be;
      r_addr  <= io_bus.addr;
      r_wdata <= io_bus.wdata;
    end
  end

  // With zero wait states the RAM access shares its edge with the accept,
  // before the latch holds the request, so IDLE forwards the bus fields that
  // are being latched on that same edge.
  always_comb begin
    w_curWe    = r_we;
    w_curBe    = r_be;
    w_curAddr  = r_addr;
    w_curWdata = r_wdata;
    if (r_state == IDLE) begin
      w_curWe    = io_bus.we;
      w_curBe    = io_bus.be;
      w_curAddr  = io_bus.addr;
      w_curWdata = io_bus.wdata;
    end
  end

  assign w_enterResp = (w_nextState == RESP) && (r_state != RESP);
  assign w_ok        = addr_ok(w_curAddr, DEPTH_WORDS);
  assign w_ramEn     = w_enterResp && w_ok;

  // Response flags, captured on the edge into RESP and held until the next
  // response. r_rdSel gates the RAM's read register onto rdata, so writes
  // and errors return zero while the RAM keeps its last read word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err   <= 1'b0;
      r_rdSel <= 1'b0;
    end else if (w_enterResp) begin
      r_err   <= !w_ok;
      r_rdSel <= w_ok && !w_curWe;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .i_clk   (i_clk),
    .i_en    (w_ramEn),
    .i_we    (w_curWe),
    .i_be    (w_curBe),
    .i_idx   (w_curAddr[IDX_W+1:2]),
    .i_wdata (w_curWdata),
    .o_rdata (w_ramRdata)
  );

  assign io_bus.ready = w_ready;
  assign io_bus.err   = r_err;
  assign io_bus.rdata = r_rdSel ? w_ramRdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed self-checking bench. Two responders share clock and reset:
// dut2 with two wait states and dut0 with none, both 64 words deep.
module tb_dmem_responder;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  dmem_if bus2 ();
  dmem_if bus0 ();

  dmem_responder #(
    .DEPTH_WORDS(64),
    .WAIT_CYCLES(2)
  ) dut2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus2)
  );

  dmem_responder #(
    .DEPTH_WORDS(64),
    .WAIT_CYCLES(0)
  ) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the request side of one bus: z=1 selects dut0, z=0 selects dut2.
  task automatic applyStimulus(input bit z, input logic r, input logic w,
                               input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d);
    if (z) begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.be = b; bus0.wdata = d;
    end else begin
      bus2.req = r; bus2.we = w; bus2.addr = a; bus2.be = b; bus2.wdata = d;
    end
  endtask

  function automatic logic readyOf(input bit z);
    return z ? bus0.ready : bus2.ready;
  endfunction

  function automatic logic [31:0] rdataOf(input bit z);
    return z ? bus0.rdata : bus2.rdata;
  endfunction

  function automatic logic errOf(input bit z);
    return z ? bus0.err : bus2.err;
  endfunction

  // One complete transaction from IDLE. lat counts edges after the accept
  // edge until ready is seen; rAfter is ready one cycle after the pulse.
  // Returns #1 after the edge back into IDLE.
  task automatic runTx(input bit z, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rd, output logic e,
                       output int lat, output logic rAfter);
    bit seen;
    int n;
    seen = 0; n = 0; lat = -1; rd = '0; e = 1'b0;
    @(negedge clk);
    applyStimulus(z, 1'b1, w, a, b, d);
    @(posedge clk); #1;
    while (!seen && n < 20) begin
      if (readyOf(z) === 1'b1) begin
        seen = 1; lat = n; rd = rdataOf(z); e = errOf(z);
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    applyStimulus(z, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    if (!seen) begin
      total++; bad++;
      $display("[TB] FAIL tx_timeout: addr %h got no ready in 20 cycles", a);
    end
    @(posedge clk); #1;
    rAfter = readyOf(z);
  endtask

  task automatic test_reset();
    #12;
    total++; if (bus2.ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", bus2.ready); end
    total++; if (bus2.err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", bus2.err); end
    total++; if (bus2.rdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", bus2.rdata); end
    total++; if (bus0.ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready0: got %b want 0", bus0.ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e; int lat; logic ra;
    runTx(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, e, lat, ra);
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL wr_latency: got %0d want 2", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL wr_err: got %b want 0", e); end
    total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL wr_rdata: got %h want 0", rd); end
    total++; if (ra !== 1'b0) begin bad++; $display("[TB] FAIL wr_pulse: ready %b after pulse, want 0", ra); end
    runTx(0, 1'b0, 32'h10, 4'h0, 32'd0, rd, e, lat, ra);
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL rd_latency: got %0d want 2", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd_data: got %h want deadbeef", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL rd_err: got %b want 0", e); end
    total++; if (bus2.rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd_hold: got %h want deadbeef", bus2.rdata); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; logic e; int lat; logic ra;
    runTx(0, 1'b1, 32'h20, 4'hF, 32'h11223344, rd, e, lat, ra);
    runTx(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd, e, lat, ra);
    runTx(0, 1'b0, 32'h20, 4'h0, 32'd0, rd, e, lat, ra);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL byte_mask: got %h want 11bb33dd", rd); end
    runTx(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, rd, e, lat, ra);
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL be0_err: got %b want 0", e); end
    runTx(0, 1'b0, 32'h20, 4'h0, 32'd0, rd, e, lat, ra);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL be0_noop: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat; logic ra;
    runTx(0, 1'b0, 32'h10, 4'h0, 32'd0, rd, e, lat, ra);
    runTx(0, 1'b0, 32'h13, 4'h0, 32'd0, rd, e, lat, ra);
    total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL misalign_err: got %b want 1", e); end
    total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL misalign_rdata: got %h want 0", rd); end
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL misalign_latency: got %0d want 2", lat); end
    total++; if (bus2.err !== 1'b1) begin bad++; $display("[TB] FAIL err_hold: got %b want 1", bus2.err); end
    runTx(0, 1'b1, 32'hFC, 4'hF, 32'hCAFEF00D, rd, e, lat, ra);
    runTx(0, 1'b1, 32'h100, 4'hF, 32'h12345678, rd, e, lat, ra);
    total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL range_err: got %b want 1", e); end
    runTx(0, 1'b0, 32'hFC, 4'h0, 32'd0, rd, e, lat, ra);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL range_neighbour: got %h want cafef00d", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL last_word_err: got %b want 0", e); end
    runTx(0, 1'b0, 32'h80000000, 4'h0, 32'd0, rd, e, lat, ra);
    total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL high_addr_err: got %b want 1", e); end
  endtask

  task automatic test_zero_latency();
    logic [31:0] rd; logic e; int lat; logic ra;
    logic [31:0] addrs [3];
    logic [31:0] expD [3];
    logic expR;
    int r;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h0;
    expD[0] = 32'h01010101; expD[1] = 32'h02020202; expD[2] = 32'h01010101;
    runTx(1, 1'b1, 32'h0, 4'hF, 32'h01010101, rd, e, lat, ra);
    total++; if (lat != 0) begin bad++; $display("[TB] FAIL zl_latency: got %0d want 0", lat); end
    runTx(1, 1'b1, 32'h4, 4'hF, 32'h02020202, rd, e, lat, ra);
    r = 0;
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b0, addrs[0], 4'h0, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      expR = ((k % 2) == 0);
      total++;
      if (bus0.ready !== expR) begin
        bad++; $display("[TB] FAIL zl_ready_cycle%0d: got %b want %b", k, bus0.ready, expR);
      end
      if (bus0.ready === 1'b1 && r < 3) begin
        total++;
        if (bus0.rdata !== expD[r]) begin
          bad++; $display("[TB] FAIL zl_rdata%0d: got %h want %h", r, bus0.rdata, expD[r]);
        end
        r++;
        if (r < 3) bus0.addr = addrs[r];
      end
    end
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat; logic ra;
    runTx(0, 1'b1, 32'h08, 4'hF, 32'h0000AAAA, rd, e, lat, ra);
    runTx(0, 1'b0, 32'h08, 4'h0, 32'd0, rd, e, lat, ra);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 32'h08, 4'hF, 32'h00000055);
    @(posedge clk); #1;
    total++; if (bus2.rdata !== 32'h0000AAAA) begin bad++; $display("[TB] FAIL wait_hold_rdata: got %h want 0000aaaa", bus2.rdata); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus2.ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_ready: got %b want 0", bus2.ready); end
    total++; if (bus2.rdata !== 32'd0) begin bad++; $display("[TB] FAIL mid_rst_rdata: got %h want 0", bus2.rdata); end
    total++; if (bus2.err !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_err: got %b want 0", bus2.err); end
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    runTx(0, 1'b0, 32'h08, 4'h0, 32'd0, rd, e, lat, ra);
    total++; if (rd !== 32'h0000AAAA) begin bad++; $display("[TB] FAIL mid_rst_ram: got %h want 0000aaaa", rd); end
    // Reset while an error response is on the bus.
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h13, 4'h0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    total++; if (bus2.err !== 1'b1 || bus2.ready !== 1'b1) begin bad++; $display("[TB] FAIL resp_err_pre: got ready %b err %b want 1 1", bus2.ready, bus2.err); end
    rst_n = 1'b0;
    #1;
    total++; if (bus2.ready !== 1'b0) begin bad++; $display("[TB] FAIL resp_rst_ready: got %b want 0", bus2.ready); end
    total++; if (bus2.err !== 1'b0) begin bad++; $display("[TB] FAIL resp_rst_err: got %b want 0", bus2.err); end
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_input_change();
    logic [31:0] rd; logic e; int lat; logic ra;
    bit seen;
    int n;
    runTx(0, 1'b1, 32'h28, 4'hF, 32'h0BADCAFE, rd, e, lat, ra);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 32'h24, 4'hF, 32'h13572468);
    @(posedge clk);
    @(negedge clk);
    bus2.addr  = 32'h28;
    bus2.wdata = 32'hFFFFFFFF;
    seen = 0; n = 1;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      if (bus2.ready === 1'b1) begin
        seen = 1; lat = n; e = bus2.err;
      end else begin
        n++;
      end
    end
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    total++; if (!seen || lat != 2) begin bad++; $display("[TB] FAIL chg_latency: got %0d want 2", seen ? lat : -1); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL chg_err: got %b want 0", e); end
    @(posedge clk); #1;
    runTx(0, 1'b0, 32'h24, 4'h0, 32'd0, rd, e, lat, ra);
    total++; if (rd !== 32'h13572468) begin bad++; $display("[TB] FAIL chg_latched_word: got %h want 13572468", rd); end
    runTx(0, 1'b0, 32'h28, 4'h0, 32'd0, rd, e, lat, ra);
    total++; if (rd !== 32'h0BADCAFE) begin bad++; $display("[TB] FAIL chg_other_word: got %h want 0badcafe", rd); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    $display("[TB] starting dmem_responder bench");
    test_reset();
    test_write_read();
    test_byte_mask();
    test_errors();
    test_zero_latency();
    test_reset_mid();
    test_input_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 32-bit CPU: the slave end of the load/store port that the datapath drives with address, write data and write strobe. It accepts one request at a time over a req/ready handshake, inserts a programmable number of wait states, performs a word or byte-masked write or a word read on an internal RAM, and flags misaligned or out-of-range accesses. It sits between the datapath's memory port and the on-chip data RAM, and lets the core be tested against non-zero memory latency.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words in the RAM; power of two, ≥ 2.
- WAIT_CYCLES, 2: wait states between accept and response; 0–15.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request valid; held high with addr/we/be/wdata stable until ready.
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address.
- be  input  4  byte enables for writes; be[i] enables wdata[8i+7:8i]; ignored on reads.
- wdata  input  32  write data.
- ready  output  1  one-cycle response pulse; the transaction completes in this cycle.
- rdata  output  32  read data, valid while ready=1 for a good read.
- err  output  1  valid while ready=1: access was misaligned or out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if req=1, latch addr, we, be and wdata, and load the wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
- WAIT: decrement the counter each cycle. When the counter is 1, go to RESP.
- RESP: ready=1 for exactly one cycle, then return to IDLE.
- The RAM access happens on the edge that enters RESP, using only the latched values.
- Bus input changes after accept are ignored.
- Error check on the latched address: err=1 if addr[1:0]≠0 or addr[31:2] ≥ DEPTH_WORDS.
- On error: no RAM write, rdata=0.
- Good write: update only the bytes selected by be. be=0000 is a legal no-op. rdata=0.
- Good read: rdata = RAM[addr[31:2]].
- rdata and err are registered. They hold their value outside RESP until the next response.
- In RESP, req is not sampled. A new request is accepted no earlier than the cycle after ready, in IDLE.
- The initiator must drop req, or present a new request, in the cycle after ready. A req still high in IDLE is treated as a new transaction.

## Timing
- Request accepted at edge T (IDLE, req=1): ready is high in cycle T+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives ready in the cycle immediately after accept.
- Maximum throughput: one transaction per WAIT_CYCLES+2 cycles.
- Reset assertion, asynchronous, at any time:
  - state=IDLE, counter=0, ready=0, err=0, rdata=0.
  - Any transaction in flight is aborted with no RAM write.
- RAM contents are not reset and are undefined after power-up.
- Reset deassertion: the first accept can happen on the first rising edge with reset=1.
- Read-after-write to the same word in back-to-back transactions returns the new data. The write completes at the RESP edge, before the next accept.

## Structure
- Package dmem_pkg:
  - state enum dmem_state_t {IDLE, WAIT, RESP};
  - constant WORD_BYTES=4;
  - function addr_ok(addr, depth) returning the alignment and range check.
- Sub-module dmem_array: synchronous-write, registered-read RAM.
  - Parameter DEPTH_WORDS.
  - Ports clk, en, we, be[3:0], idx, wdata, rdata.
  - No reset.
- Top level: FSM, wait counter, request latch, error logic.

## Test plan
- Write then read, WAIT_CYCLES=2: write addr 0x10, wdata 0xDEADBEEF, be=1111 -> ready 3 cycles after accept, err=0. Read 0x10 -> rdata 0xDEADBEEF.
- Byte mask: word 0x20 holds 0x11223344. Write 0xAABBCCDD with be=0101 -> a read returns 0x11BB33DD.
- Errors:
  - read at 0x13 -> ready with err=1, rdata=0;
  - write at 4×DEPTH_WORDS -> err=1, and that word's neighbour 4×DEPTH_WORDS−4 is unchanged.
- Zero latency, WAIT_CYCLES=0, req held high continuously:
  - ready in every second cycle;
  - each response reflects the inputs latched at its own accept.
- Reset mid-transaction: assert reset in WAIT during a write of 0x55 to 0x08 -> ready and err drop at once. After release, word 0x08 still holds its old value.
- Input changes after accept: change addr and wdata in the cycle after accept -> the response and RAM update use the originally latched values.
